// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_ctrl
//  Brief    : Fetch-stage controller for a 5-stage RISC-V pipeline. Sequences
//             the PC unit and the IF/ID register, arbitrating between an EX
//             branch redirect, an ID load-use stall and the instruction-memory
//             handshake. Squashes an in-flight wrong-path fetch and keeps
//             saturating stall/flush performance counters.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,            // asynchronous, active-low
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  branch_target,
  input  logic             stall_id,
  output logic             imem_req,
  input  logic             imem_ready,
  output logic             pc_write,
  output logic             pc_redirect,
  output logic [XLEN-1:0]  redirect_target,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  // --------------------------------------------------------------------------
  // State encoding. The debug port exposes the raw encoding, so the values
  // are fixed: BOOT=0, FETCH=1, SQUASH=2. Encoding 3 is unreachable and is
  // steered back to BOOT if it is ever observed.
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_SQUASH  = 2'd2,
    ST_ILLEGAL = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d;

  // Event strobes feeding the performance counters.
  logic             stall_evt;
  logic             flush_evt;

  // State register; reset drops straight to BOOT and forgets any squash.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control outputs: the branch outranks the load-use stall
  // (a stalled instruction behind a taken branch is wrong-path anyway), and
  // the stall outranks the memory handshake.
  always_comb begin
    state_d     = state_q;
    imem_req    = 1'b0;
    pc_write    = 1'b0;
    pc_redirect = 1'b0;
    if_id_write = 1'b0;
    if_id_flush = 1'b0;

    unique case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
      end

      ST_FETCH: begin
        imem_req = 1'b1;
        if (branch_taken) begin
          pc_redirect = 1'b1;
          pc_write    = 1'b1;
          if_id_flush = 1'b1;
          // If the current fetch has not returned yet it belongs to the old
          // path and must be thrown away when it does.
          state_d     = imem_ready ? ST_FETCH : ST_SQUASH;
        end else if (stall_id) begin
          // PC held; memory keeps presenting the same instruction.
          pc_write    = 1'b0;
          if_id_write = 1'b0;
        end else if (imem_ready) begin
          pc_write    = 1'b1;
          if_id_write = 1'b1;
        end
      end

      ST_SQUASH: begin
        imem_req = 1'b1;
        if (branch_taken) begin
          pc_redirect = 1'b1;
          pc_write    = 1'b1;
          if_id_flush = 1'b1;
          state_d     = imem_ready ? ST_FETCH : ST_SQUASH;
        end else if (imem_ready) begin
          // Wrong-path instruction arrives: load a bubble instead.
          if_id_flush = 1'b1;
          state_d     = ST_FETCH;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // Counter events are derived from the decoded controls so they always
  // agree with what the PC unit and IF/ID register actually saw.
  always_comb begin
    stall_evt = 1'b0;
    flush_evt = if_id_flush;
    if ((state_q == ST_FETCH) || (state_q == ST_SQUASH)) begin
      stall_evt = ~pc_write;
    end
  end

  // Saturating increment: counters stick at all-ones rather than wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_evt && (stall_cnt_q != C_CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + C_CNT_ONE;
    end
    if (flush_evt && (flush_cnt_q != C_CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + C_CNT_ONE;
    end
  end

  // Performance counter registers, cleared together with the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Output mapping; the redirect address is gated so it reads zero whenever
  // no redirect is being requested.
  assign redirect_target = pc_redirect ? branch_target : '0;
  assign state           = state_q;
  assign stall_count     = stall_cnt_q;
  assign flush_count     = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_ctrl
//  Brief    : Self-checking bench for fetch_ctrl. Directed vector table with
//             a behavioural PC unit, plus hand-written async-reset sequence.
//             A second instance with 3-bit counters exercises saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

  localparam int XLEN  = 64;
  localparam int CNT_W = 32;
  localparam int SMALL = 3;

  logic             clk;
  logic             reset;
  logic             branch_taken;
  logic [XLEN-1:0]  branch_target;
  logic             stall_id;
  logic             imem_ready;

  logic             imem_req;
  logic             pc_write;
  logic             pc_redirect;
  logic [XLEN-1:0]  redirect_target;
  logic             if_id_write;
  logic             if_id_flush;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  logic             s_imem_req;
  logic             s_pc_write;
  logic             s_pc_redirect;
  logic [XLEN-1:0]  s_redirect_target;
  logic             s_if_id_write;
  logic             s_if_id_flush;
  logic [1:0]       s_state;
  logic [SMALL-1:0] s_stall_count;
  logic [SMALL-1:0] s_flush_count;

  fetch_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .stall_id(stall_id), .imem_req(imem_req), .imem_ready(imem_ready),
    .pc_write(pc_write), .pc_redirect(pc_redirect),
    .redirect_target(redirect_target), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .state(state),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  fetch_ctrl #(.XLEN(XLEN), .CNT_W(SMALL)) dut_sat (
    .clk(clk), .reset(reset),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .stall_id(stall_id), .imem_req(s_imem_req), .imem_ready(imem_ready),
    .pc_write(s_pc_write), .pc_redirect(s_pc_redirect),
    .redirect_target(s_redirect_target), .if_id_write(s_if_id_write),
    .if_id_flush(s_if_id_flush), .state(s_state),
    .stall_count(s_stall_count), .flush_count(s_flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural PC unit driven by the controller outputs.
  logic [XLEN-1:0] pc;
  always @(posedge clk or negedge reset) begin
    if (!reset)        pc <= '0;
    else if (pc_write) pc <= pc_redirect ? redirect_target : pc + 64'd4;
  end

  typedef struct {
    logic            br;
    logic [XLEN-1:0] tgt;
    logic            st;
    logic            rdy;
    logic [1:0]      e_state;
    logic [4:0]      e_ctl;   // {imem_req, pc_write, pc_redirect, if_id_write, if_id_flush}
    logic [XLEN-1:0] e_tgt;
    logic [XLEN-1:0] e_pc;
    int              e_sc;
    int              e_fc;
  } vec_t;

  vec_t vecs[32];
  int   nv;
  int   passed;
  int   total;

  task automatic add(input logic br, input logic [XLEN-1:0] tgt, input logic st,
                     input logic rdy, input logic [1:0] es, input logic [4:0] ec,
                     input logic [XLEN-1:0] et, input logic [XLEN-1:0] ep,
                     input int sc, input int fc);
    vecs[nv].br = br;  vecs[nv].tgt = tgt; vecs[nv].st = st; vecs[nv].rdy = rdy;
    vecs[nv].e_state = es; vecs[nv].e_ctl = ec; vecs[nv].e_tgt = et;
    vecs[nv].e_pc = ep; vecs[nv].e_sc = sc; vecs[nv].e_fc = fc;
    nv++;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  function automatic logic [63:0] sat(input int v);
    return (v > 7) ? 64'd7 : 64'(v);
  endfunction

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    passed = 0; total = 0; nv = 0;
    reset = 1'b0; branch_taken = 1'b1; branch_target = 64'd55;
    stall_id = 1'b0; imem_ready = 1'b1;

    //   br tgt       st rdy  state  ctl rq/pw/rd/wr/fl  e_tgt   pc     sc fc
    add(0, 64'd0,   0, 1, 2'd0, 5'b00000, 64'd0,   64'd0,   0, 0); // BOOT
    add(0, 64'd0,   0, 1, 2'd1, 5'b11010, 64'd0,   64'd0,   0, 0);
    add(0, 64'd0,   0, 1, 2'd1, 5'b11010, 64'd0,   64'd4,   0, 0);
    add(0, 64'd0,   0, 1, 2'd1, 5'b11010, 64'd0,   64'd8,   0, 0);
    add(0, 64'd0,   1, 1, 2'd1, 5'b10000, 64'd0,   64'd12,  0, 0); // load-use
    add(0, 64'd0,   1, 1, 2'd1, 5'b10000, 64'd0,   64'd12,  1, 0);
    add(0, 64'd0,   0, 1, 2'd1, 5'b11010, 64'd0,   64'd12,  2, 0);
    add(1, 64'd100, 0, 1, 2'd1, 5'b11101, 64'd100, 64'd16,  2, 0); // branch+ready
    add(0, 64'd0,   0, 1, 2'd1, 5'b11010, 64'd0,   64'd100, 2, 1);
    add(1, 64'd200, 0, 0, 2'd1, 5'b11101, 64'd200, 64'd104, 2, 1); // branch, wait
    add(0, 64'd0,   0, 0, 2'd2, 5'b10000, 64'd0,   64'd200, 2, 2); // squash wait
    add(0, 64'd0,   0, 1, 2'd2, 5'b10001, 64'd0,   64'd200, 3, 2); // discard
    add(0, 64'd0,   0, 1, 2'd1, 5'b11010, 64'd0,   64'd200, 4, 3);
    add(1, 64'd300, 1, 1, 2'd1, 5'b11101, 64'd300, 64'd204, 4, 3); // all three
    add(0, 64'd0,   0, 0, 2'd1, 5'b10000, 64'd0,   64'd300, 4, 4); // mem wait
    add(1, 64'd400, 0, 0, 2'd1, 5'b11101, 64'd400, 64'd300, 5, 4);
    add(1, 64'd500, 0, 0, 2'd2, 5'b11101, 64'd500, 64'd400, 5, 5); // squash+branch
    add(1, 64'd600, 0, 1, 2'd2, 5'b11101, 64'd600, 64'd500, 5, 6); // squash+branch+rdy
    add(0, 64'd0,   0, 1, 2'd1, 5'b11010, 64'd0,   64'd600, 5, 7);
    add(1, 64'd700, 0, 0, 2'd1, 5'b11101, 64'd700, 64'd604, 5, 7);
    add(0, 64'd0,   1, 0, 2'd2, 5'b10000, 64'd0,   64'd700, 5, 8); // stall ignored

    // Reset state, with inputs that would otherwise drive controls.
    #2;
    chk("reset_state", 64'(state), 64'd0);
    chk("reset_ctl", 64'({imem_req, pc_write, pc_redirect, if_id_write, if_id_flush}), 64'd0);
    chk("reset_tgt", redirect_target, 64'd0);
    chk("reset_cnt", 64'(stall_count) + 64'(flush_count), 64'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < nv; i++) begin
      branch_taken = vecs[i].br; branch_target = vecs[i].tgt;
      stall_id = vecs[i].st; imem_ready = vecs[i].rdy;
      #2;
      chk($sformatf("v%0d_state", i), 64'(state), 64'(vecs[i].e_state));
      chk($sformatf("v%0d_ctl", i),
          64'({imem_req, pc_write, pc_redirect, if_id_write, if_id_flush}), 64'(vecs[i].e_ctl));
      chk($sformatf("v%0d_tgt", i), redirect_target, vecs[i].e_tgt);
      chk($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
      chk($sformatf("v%0d_stall_cnt", i), 64'(stall_count), 64'(vecs[i].e_sc));
      chk($sformatf("v%0d_flush_cnt", i), 64'(flush_count), 64'(vecs[i].e_fc));
      chk($sformatf("v%0d_sat_stall", i), 64'(s_stall_count), sat(vecs[i].e_sc));
      chk($sformatf("v%0d_sat_flush", i), 64'(s_flush_count), sat(vecs[i].e_fc));
      @(negedge clk);
    end

    // After the last vector: SQUASH, stall_count=6, flush_count=8 (small: 7).
    branch_taken = 1'b1; branch_target = 64'd800; stall_id = 1'b0; imem_ready = 1'b1;
    #1;
    chk("pre_rst_state", 64'(state), 64'd2);
    chk("pre_rst_stall", 64'(stall_count), 64'd6);
    chk("pre_rst_flush", 64'(flush_count), 64'd8);
    chk("pre_rst_sat_flush", 64'(s_flush_count), 64'd7);
    // Asynchronous reset pulse between clock edges.
    reset = 1'b0;
    #1;
    chk("async_state", 64'(state), 64'd0);
    chk("async_ctl", 64'({imem_req, pc_write, pc_redirect, if_id_write, if_id_flush}), 64'd0);
    chk("async_tgt", redirect_target, 64'd0);
    chk("async_stall", 64'(stall_count), 64'd0);
    chk("async_flush", 64'(flush_count), 64'd0);
    #1;
    reset = 1'b1;
    branch_taken = 1'b0; imem_ready = 1'b1;
    #1;
    chk("post_rst_boot", 64'(state), 64'd0);
    @(negedge clk);
    #1;
    chk("post_rst_fetch", 64'(state), 64'd1);
    chk("post_rst_ctl", 64'({imem_req, pc_write, pc_redirect, if_id_write, if_id_flush}), 64'b11010);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Fetch-stage controller that sequences the PC unit and the IF/ID register of the 5-stage RISC-V pipeline.
- Arbitrates between three sources: EX-stage branch redirect, ID-stage load-use stall and instruction-memory handshake.
- Generates PCWrite, BranchTaken and BranchTarget for the PC unit, plus IF/ID write and flush controls.
- Tracks an in-flight wrong-path fetch so it can be squashed, and keeps stall and flush performance counters.

Parameters:
- XLEN, 64, width of the PC and the branch target.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state.
- branch_taken  in  1  EX stage resolved a taken branch or jump.
- branch_target  in  XLEN  redirect address from EX.
- stall_id  in  1  load-use hazard from the hazard detection unit.
- imem_req  out  1  fetch request to instruction memory.
- imem_ready  in  1  instruction memory returns the instruction this cycle.
- pc_write  out  1  drives PCWrite of the PC unit.
- pc_redirect  out  1  drives BranchTaken of the PC unit.
- redirect_target  out  XLEN  drives BranchTarget of the PC unit.
- if_id_write  out  1  IF/ID register load enable.
- if_id_flush  out  1  IF/ID register clears to a bubble (NOP).
- state  out  2  debug encoding: BOOT=0, FETCH=1, SQUASH=2.
- stall_count  out  CNT_W  cycles in FETCH/SQUASH with pc_write=0.
- flush_count  out  CNT_W  number of cycles with if_id_flush=1.

Behaviour:
- Reset (reset=0, asynchronous): state=BOOT; stall_count=0; flush_count=0. All control outputs are 0 and redirect_target=0 while in BOOT.
- Control outputs are Moore/Mealy combinational functions of state and inputs; only state and the counters are registered.
- redirect_target = branch_target when pc_redirect=1, else 0.
- BOOT:
  - All controls 0.
  - Next state is FETCH unconditionally on the first rising clk edge after reset rises.
- FETCH: imem_req=1. Priority order, highest first:
  1. branch_taken=1: pc_redirect=1, pc_write=1, if_id_flush=1, if_id_write=0. Next state is FETCH if imem_ready=1, else SQUASH, because the outstanding fetch is wrong-path.
  2. stall_id=1: pc_write=0, if_id_write=0. State stays FETCH. The instruction memory holds its output while the PC is unchanged.
  3. imem_ready=1: pc_write=1, if_id_write=1. The PC advances by 4 inside the PC unit.
  4. Otherwise (memory wait): pc_write=0, if_id_write=0.
- SQUASH: imem_req=1; if_id_write=0.
  - branch_taken=1: same redirect outputs as FETCH priority 1. State stays SQUASH unless imem_ready=1, in which case next state is FETCH.
  - Otherwise, imem_ready=1: the returned instruction is discarded (pc_write=0, if_id_flush=1). Next state is FETCH.
  - Otherwise: all controls 0 except imem_req.
- Counters:
  - stall_count increments when state is FETCH or SQUASH and pc_write=0.
  - flush_count increments on every cycle with if_id_flush=1.
  - Both saturate at all-ones and never wrap.
- Simultaneous branch_taken, stall_id and imem_ready: the branch wins and the stall is ignored, since the stalled instruction is wrong-path.
- Reset asserted mid-operation: immediate return to BOOT. Any pending squash is forgotten and the counters clear.
- Unused state encoding 3: next state is BOOT.

Test Plan:
- Reset: hold reset=0 for 2 cycles, release, keep imem_ready=1 → BOOT for 1 cycle, then pc_write=1 every cycle. PC unit goes 0, 4, 8, 12; stall_count=0.
- Load-use stall: stall_id=1 for 2 cycles with imem_ready=1 and PC=12 → pc_write=0 and if_id_write=0 for those 2 cycles; PC holds 12; stall_count=2; then resumes to 16.
- Branch with ready: branch_taken=1, branch_target=100, imem_ready=1 → pc_redirect=1, redirect_target=100, if_id_flush=1; next PC=100 then 104; flush_count=1; state stays FETCH.
- Branch during memory wait: imem_ready=0 with branch_taken=1 and target=200 → SQUASH. Two cycles later imem_ready=1 → that instruction discarded with if_id_flush=1 and if_id_write=0, back to FETCH. PC 200 then 204; flush_count=2.
- Branch, stall and ready all in one cycle with target=300 → redirect to 300 and stall ignored; pc_write=1, if_id_flush=1.
- Asynchronous reset pulse between clock edges while in SQUASH → state=0 and counters=0 immediately, without waiting for a clk edge; all controls 0.
